// File: rtl/div_16bit_seq.sv
// ============================================================================
// Module   : div_16bit_seq
// Brief    : Sequential restoring shift-subtract divider, one quotient bit per
//            clock, start/busy/done handshake. Define SIGNED_DIV_EN for
//            two's-complement operands with sign fix-up and overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_16bit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             ovfl
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             q_bit;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] quo_fin, rem_fin;

`ifdef SIGNED_DIV_EN
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;
  logic ovf_pend_q, ovf_pend_d;
  logic ovfl_q, ovfl_d;

  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    quo_fin = q_neg_q ? (~step_quo + 1'b1) : step_quo;
    rem_fin = r_neg_q ? (~step_rem + 1'b1) : step_rem;
  end
`else
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    quo_fin = step_quo;
    rem_fin = step_rem;
  end
`endif

  // The shifted value is the 17-bit partial remainder; its bit 16 feeds the
  // subtract so the borrow in trial[WIDTH] is exact.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_q};
    q_bit    = ~trial[WIDTH];
    step_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    step_quo = {dvd_q[WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
`ifdef SIGNED_DIV_EN
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    ovf_pend_d  = ovf_pend_q;
    ovfl_d      = ovfl_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          rem_d   = '0;
          if (divisor == '0) begin
            // Single pass-through cycle gives the two-cycle divide-by-zero latency.
            zero_d = 1'b1;
            dvd_d  = dividend;
            cnt_d  = '0;
`ifdef SIGNED_DIV_EN
            ovf_pend_d = 1'b0;
`endif
          end else begin
            zero_d = 1'b0;
            dvd_d  = dvd_mag;
            dvs_d  = dvs_mag;
            cnt_d  = CW'(WIDTH - 1);
`ifdef SIGNED_DIV_EN
            q_neg_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_d    = dividend[WIDTH-1];
            ovf_pend_d = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`endif
          end
        end
      end

      S_CALC: begin
        if (zero_q) begin
          state_d     = S_DONE;
          quotient_d  = '1;
          remainder_d = dvd_q;
          div_zero_d  = 1'b1;
`ifdef SIGNED_DIV_EN
          ovfl_d      = 1'b0;
`endif
        end else begin
          rem_d = step_rem;
          dvd_d = step_quo;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d     = S_DONE;
            quotient_d  = quo_fin;
            remainder_d = rem_fin;
            div_zero_d  = 1'b0;
`ifdef SIGNED_DIV_EN
            ovfl_d      = ovf_pend_q;
`endif
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      ovf_pend_q  <= 1'b0;
      ovfl_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
`ifdef SIGNED_DIV_EN
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      ovf_pend_q  <= ovf_pend_d;
      ovfl_q      <= ovfl_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = (state_q == S_CALC);
  assign done      = (state_q == S_DONE);
  assign div_zero  = div_zero_q;
`ifdef SIGNED_DIV_EN
  assign ovfl      = ovfl_q;
`else
  assign ovfl      = 1'b0;
`endif

endmodule

`default_nettype wire
